// File: rtl/mem_responder.sv
// Memory responder: 1W/4R CPU memory with program-load engine and CPU hold.
// Define MEM_WR_BYPASS_EN for write-first forwarding on same-address reads.
module mem_responder #(
    parameter int AW = 14,
    parameter int DW = 10,
    parameter logic [AW-1:0] LOAD_BASE = 14'h2000
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          m_write,
    input  logic [AW-1:0] m_inaddr,
    input  logic [DW-1:0] m_indata,
    input  logic          m_read1,
    input  logic          m_read2,
    input  logic          m_read3,
    input  logic          m_read4,
    input  logic [AW-1:0] m_outaddr1,
    input  logic [AW-1:0] m_outaddr2,
    input  logic [AW-1:0] m_outaddr3,
    input  logic [AW-1:0] m_outaddr4,
    output logic [DW-1:0] m_outdata1,
    output logic [DW-1:0] m_outdata2,
    output logic [DW-1:0] m_outdata3,
    output logic [DW-1:0] m_outdata4,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          ld_skip,
    output logic          ld_ready,
    output logic          cpu_hold,
    output logic [AW:0]   ld_count,
    output logic          ld_err
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_LOAD,
        S_RUN
    } state_t;

    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] mem [2**AW];

    logic run;
    logic skip_now;
    logic accept;
    logic at_top;
    logic [3:0] hit;

    assign run      = (state == S_RUN);
    assign skip_now = (state == S_WAIT) && ld_skip;
    assign accept   = ld_ready && ld_valid && !skip_now;
    assign at_top   = (ptr == {AW{1'b1}});

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= S_WAIT;
            cpu_hold <= 1'b1;
            ld_ready <= 1'b0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            ptr      <= LOAD_BASE;
        end else begin
            unique case (state)
                S_WAIT, S_LOAD: begin
                    if (skip_now) begin
                        state    <= S_RUN;
                        cpu_hold <= 1'b0;
                        ld_ready <= 1'b0;
                    end else if (accept) begin
                        if (ld_count != CNT_MAX)
                            ld_count <= ld_count + 1'b1;
                        // no wrap: the top word ends the load
                        if (!at_top)
                            ptr <= ptr + 1'b1;
                        if (ld_last || at_top) begin
                            state    <= S_RUN;
                            cpu_hold <= 1'b0;
                            ld_ready <= 1'b0;
                            ld_err   <= ld_err | at_top;
                        end else begin
                            state    <= S_LOAD;
                            ld_ready <= 1'b1;
                        end
                    end else begin
                        ld_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    cpu_hold <= 1'b0;
                    ld_ready <= 1'b0;
                end
                default: begin
                    state    <= S_WAIT;
                    cpu_hold <= 1'b1;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept)
            mem[ptr] <= ld_data;
        else if (run && m_write)
            mem[m_inaddr] <= m_indata;
    end

`ifdef MEM_WR_BYPASS_EN
    assign hit[0] = m_write && (m_outaddr1 == m_inaddr);
    assign hit[1] = m_write && (m_outaddr2 == m_inaddr);
    assign hit[2] = m_write && (m_outaddr3 == m_inaddr);
    assign hit[3] = m_write && (m_outaddr4 == m_inaddr);
`else
    assign hit = 4'b0000;
`endif

    assign m_outdata1 = !(run && m_read1) ? '0 :
                        hit[0] ? m_indata : mem[m_outaddr1];
    assign m_outdata2 = !(run && m_read2) ? '0 :
                        hit[1] ? m_indata : mem[m_outaddr2];
    assign m_outdata3 = !(run && m_read3) ? '0 :
                        hit[2] ? m_indata : mem[m_outaddr3];
    assign m_outdata4 = !(run && m_read4) ? '0 :
                        hit[3] ? m_indata : mem[m_outaddr4];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: load, skip, CPU access, overflow, reset.
module tb_mem_responder;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        m_write = 1'b0;
    logic [13:0] m_inaddr = '0;
    logic [9:0]  m_indata = '0;
    logic        m_read1 = 1'b0, m_read2 = 1'b0;
    logic        m_read3 = 1'b0, m_read4 = 1'b0;
    logic [13:0] m_outaddr1 = '0, m_outaddr2 = '0;
    logic [13:0] m_outaddr3 = '0, m_outaddr4 = '0;
    logic        ld_valid = 1'b0;
    logic [9:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_skip = 1'b0;

    logic [9:0]  d1, d2, d3, d4;
    logic        ld_ready, cpu_hold, ld_err;
    logic [14:0] ld_count;

    logic [9:0]  t1, t2, t3, t4;
    logic        t_ready, t_hold, t_err;
    logic [14:0] t_count;

    int checks = 0;
    int errors = 0;

    logic [9:0] wd [3];
    logic [9:0] exp_d;

    mem_responder u_dut (
        .clk_in(clk_in), .rst(rst),
        .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
        .m_read1(m_read1), .m_read2(m_read2),
        .m_read3(m_read3), .m_read4(m_read4),
        .m_outaddr1(m_outaddr1), .m_outaddr2(m_outaddr2),
        .m_outaddr3(m_outaddr3), .m_outaddr4(m_outaddr4),
        .m_outdata1(d1), .m_outdata2(d2),
        .m_outdata3(d3), .m_outdata4(d4),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_skip(ld_skip),
        .ld_ready(ld_ready), .cpu_hold(cpu_hold),
        .ld_count(ld_count), .ld_err(ld_err)
    );

    mem_responder #(.LOAD_BASE(14'h3FFE)) u_top (
        .clk_in(clk_in), .rst(rst2),
        .m_write(m_write), .m_inaddr(m_inaddr), .m_indata(m_indata),
        .m_read1(m_read1), .m_read2(m_read2),
        .m_read3(m_read3), .m_read4(m_read4),
        .m_outaddr1(m_outaddr1), .m_outaddr2(m_outaddr2),
        .m_outaddr3(m_outaddr3), .m_outaddr4(m_outaddr4),
        .m_outdata1(t1), .m_outdata2(t2),
        .m_outdata3(t3), .m_outdata4(t4),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_skip(ld_skip),
        .ld_ready(t_ready), .cpu_hold(t_hold),
        .ld_count(t_count), .ld_err(t_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rd_all(input logic [13:0] a);
        m_outaddr1 = a; m_outaddr2 = a;
        m_outaddr3 = a; m_outaddr4 = a;
        m_read1 = 1'b1; m_read2 = 1'b1;
        m_read3 = 1'b1; m_read4 = 1'b1;
    endtask

    initial begin
        wd[0] = 10'h2A5; wd[1] = 10'h013; wd[2] = 10'h3FF;

        // reset state
        m_read1 = 1'b1; m_outaddr1 = 14'h2000;
        step(); step();
        check("rst_out1", d1, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_ready", ld_ready, 0);
        check("rst_count", ld_count, 0);
        check("rst_err", ld_err, 0);
        rst = 1'b0;
        step();
        check("wait_ready", ld_ready, 1);

        // three-word load
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = wd[i]; ld_last = (i == 2);
            check("load_hold", cpu_hold, 1);
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("load_hold_fall", cpu_hold, 0);
        check("load_count", ld_count, 3);
        check("load_err", ld_err, 0);
        check("run_ready", ld_ready, 0);
        m_outaddr1 = 14'h2000; m_outaddr2 = 14'h2001;
        m_outaddr3 = 14'h2002; m_read1 = 1'b1;
        m_read2 = 1'b1; m_read3 = 1'b1;
        #1;
        check("mem2000", d1, 10'h2A5);
        check("mem2001", d2, 10'h013);
        check("mem2002", d3, 10'h3FF);

        // CPU write then read on all ports
        m_write = 1'b1; m_inaddr = 14'h0100; m_indata = 10'h155;
        step();
        m_write = 1'b0;
        rd_all(14'h0100);
        m_read2 = 1'b0;
        #1;
        check("wr_rd1", d1, 10'h155);
        check("wr_rd2_off", d2, 0);
        check("wr_rd3", d3, 10'h155);
        check("wr_rd4", d4, 10'h155);
        check("top_rst_out", t1, 0);
        m_read2 = 1'b1;
        #1;
        check("wr_rd2", d2, 10'h155);

        // same-cycle write/read collision
        m_write = 1'b1; m_inaddr = 14'h0200; m_indata = 10'h111;
        step();
        m_inaddr = 14'h0200; m_indata = 10'h0F0;
        m_outaddr1 = 14'h0200; m_read1 = 1'b1;
        #1;
`ifdef MEM_WR_BYPASS_EN
        exp_d = 10'h0F0;
`else
        exp_d = 10'h111;
`endif
        check("collide", d1, exp_d);
        step();
        m_inaddr = 14'h0300; m_indata = 10'h2AA;
        step();
        m_write = 1'b0;
        #1;
        check("after_collide", d1, 10'h0F0);

        // skip has priority over valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        ld_skip = 1'b1; ld_valid = 1'b1; ld_data = 10'h3C3;
        step();
        ld_skip = 1'b0; ld_valid = 1'b0;
        check("skip_hold", cpu_hold, 0);
        check("skip_count", ld_count, 0);
        check("skip_ready", ld_ready, 0);
        m_outaddr1 = 14'h2000; m_read1 = 1'b1;
        #1;
        check("skip_nowrite", d1, 10'h2A5);

        // reset mid-load, CPU write during load ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        m_write = 1'b1; m_inaddr = 14'h0300; m_indata = 10'h055;
        ld_valid = 1'b1; ld_data = 10'h001;
        step();
        ld_data = 10'h002;
        step();
        m_write = 1'b0; ld_valid = 1'b0;
        check("mid_count", ld_count, 2);
        check("mid_hold", cpu_hold, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_count", ld_count, 0);
        check("mid_rst_ready", ld_ready, 0);
        step();
        rst = 1'b0;
        step();
        ld_valid = 1'b1; ld_data = 10'h07E; ld_last = 1'b1;
        check("reload_hold", cpu_hold, 1);
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("reload_hold_fall", cpu_hold, 0);
        check("reload_count", ld_count, 1);
        m_outaddr1 = 14'h2000; m_outaddr2 = 14'h2001;
        m_outaddr3 = 14'h0300;
        m_read1 = 1'b1; m_read2 = 1'b1; m_read3 = 1'b1;
        #1;
        check("reload_2000", d1, 10'h07E);
        check("reload_2001", d2, 10'h002);
        check("cpu_wr_ignored", d3, 10'h2AA);

        // load past the top address
        check("top_rst_ready", t_ready, 0);
        check("top_rst_hold", t_hold, 1);
        rst2 = 1'b0;
        step();
        ld_valid = 1'b1; ld_data = 10'h101;
        step();
        check("top_err0", t_err, 0);
        check("top_ready1", t_ready, 1);
        ld_data = 10'h202;
        step();
        check("top_err1", t_err, 1);
        check("top_ready0", t_ready, 0);
        check("top_hold", t_hold, 0);
        check("top_count2", t_count, 2);
        ld_data = 10'h303;
        step();
        ld_valid = 1'b0;
        check("top_count_held", t_count, 2);
        m_outaddr1 = 14'h3FFE; m_outaddr2 = 14'h3FFF;
        m_outaddr3 = 14'h0000;
        #1;
        check("top_3ffe", t1, 10'h101);
        check("top_3fff", t2, 10'h202);
        check("top_nowrap", t3 == 10'h303, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
